// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue controller.
//   alu_op_e      : 3-bit ALU opcode encoding
//   issue_state_e : controller FSM states
//   ALU_DATA_W    : datapath width of the external ALU
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 16;

    typedef enum logic [2:0] {
        OP_SUB     = 3'b000,
        OP_ADD     = 3'b001,
        OP_MUL     = 3'b010,
        OP_DIV3    = 3'b011,
        OP_AND     = 3'b100,
        OP_SHL     = 3'b101,
        OP_SHR     = 3'b110,
        OP_ILLEGAL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response channel between the issue stage and the ALU issue controller.
//   req_valid/req_ready : request handshake, carries req_op/req_a/req_b/req_tag
//   rsp_valid/rsp_ready : response handshake, carries rsp_result/rsp_tag and flags
//   master : requester side (issue stage or bench)
//   slave  : controller side
interface alu_issue_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_zero;
    logic              rsp_neg;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_zero, rsp_neg, rsp_err
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk     : clock, rising edge
//   rst_n   : asynchronous reset, active-low
//   i_inc   : increment request (ignored once the counter is all-ones)
//   o_count : current count
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/alu_issue_ctrl.sv
// Requester-side controller for the external ALU. Accepts a request, drives registered
// operands/opcode to the ALU, waits ALU_LAT cycles, captures the result plus flags and
// returns it on the response channel. Opcode 111 is answered directly with an error.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : alu_issue_ctrl_if.slave request/response channel
//   alu_a/alu_b : operands to the ALU
//   alu_ctrl    : opcode to the ALU
//   alu_result  : ALU result
//   perf_ops    : completed responses (only with ALU_ISSUE_PERF_EN)
//   perf_err    : completed ILLEGAL responses (only with ALU_ISSUE_PERF_EN)
// Optional feature macro: ALU_ISSUE_PERF_EN
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [15:0]       perf_err
`endif
);
    if (ALU_LAT == 0 || ALU_LAT > 15) begin : g_bad_lat
        $error("alu_issue_ctrl: ALU_LAT must be in 1..15");
    end
    if (DATA_W != ALU_DATA_W) begin : g_bad_width
        $error("alu_issue_ctrl: DATA_W must equal ALU_DATA_W");
    end

    issue_state_e      r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_alu_a, w_alu_a_nxt;
    logic [DATA_W-1:0] r_alu_b, w_alu_b_nxt;
    logic [2:0]        r_alu_ctrl, w_alu_ctrl_nxt;
    logic [TAG_W-1:0]  r_tag, w_tag_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_result, w_rsp_result_nxt;
    logic              r_rsp_zero, w_rsp_zero_nxt;
    logic              r_rsp_neg, w_rsp_neg_nxt;
    logic              r_rsp_err, w_rsp_err_nxt;

    logic w_accept;
    logic w_rsp_fire;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_rsp_fire = r_rsp_valid && bus.rsp_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_alu_ctrl_nxt   = r_alu_ctrl;
        w_tag_nxt        = r_tag;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_zero_nxt   = r_rsp_zero;
        w_rsp_neg_nxt    = r_rsp_neg;
        w_rsp_err_nxt    = r_rsp_err;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tag_nxt = bus.req_tag;
                    if (bus.req_op == OP_ILLEGAL) begin
                        // ALU is left untouched; answer immediately with an error.
                        w_state_nxt      = RESP;
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = '0;
                        w_rsp_zero_nxt   = 1'b1;
                        w_rsp_neg_nxt    = 1'b0;
                        w_rsp_err_nxt    = 1'b1;
                    end else begin
                        w_state_nxt    = EXEC;
                        w_alu_a_nxt    = bus.req_a;
                        w_alu_b_nxt    = bus.req_b;
                        w_alu_ctrl_nxt = bus.req_op;
                        w_cnt_nxt      = 4'(ALU_LAT - 1);
                    end
                end
            end
            EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt      = RESP;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = alu_result;
                    w_rsp_zero_nxt   = (alu_result == '0);
                    w_rsp_neg_nxt    = alu_result[DATA_W-1];
                    w_rsp_err_nxt    = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (w_rsp_fire) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_neg    <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_alu_ctrl   <= w_alu_ctrl_nxt;
            r_tag        <= w_tag_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_zero   <= w_rsp_zero_nxt;
            r_rsp_neg    <= w_rsp_neg_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
        end
    end

    // req_ready depends on state only, so no combinational path from the handshakes.
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_tag    = r_tag;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_neg    = r_rsp_neg;
    assign bus.rsp_err    = r_rsp_err;
    assign alu_a          = r_alu_a;
    assign alu_b          = r_alu_b;
    assign alu_ctrl       = r_alu_ctrl;

`ifdef ALU_ISSUE_PERF_EN
    sat_counter #(.W(32)) u_perf_ops (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rsp_fire),
        .o_count (perf_ops)
    );

    sat_counter #(.W(16)) u_perf_err (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_rsp_fire && r_rsp_err),
        .o_count (perf_err)
    );
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT=1 and ALU_LAT=4), each behind its own
// behavioural ALU. Vectors come from a table; expected responses go through a queue.
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.DATA_W(16), .TAG_W(4)) bus1 ();
    alu_issue_ctrl_if #(.DATA_W(16), .TAG_W(4)) bus4 ();

    logic [15:0] alu_a1, alu_b1, alu_res1, alu_a4, alu_b4, alu_res4;
    logic [2:0]  alu_ctrl1, alu_ctrl4;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops1, perf_ops4;
    logic [15:0] perf_err1, perf_err4;
`endif

    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] p;
        p = {16'h0, a} * {16'h0, b};
        case (op)
            3'b000:  return a - b;
            3'b001:  return a + b;
            3'b010:  return p[15:0];
            3'b011:  return a / 16'd3;
            3'b100:  return a & b;
            3'b101:  return {a[14:0], 1'b0};
            3'b110:  return {1'b0, a[15:1]};
            default: return 16'h0;
        endcase
    endfunction

    assign alu_res1 = alu_fn(alu_ctrl1, alu_a1, alu_b1);
    assign alu_res4 = alu_fn(alu_ctrl4, alu_a4, alu_b4);

    alu_issue_ctrl #(.DATA_W(16), .TAG_W(4), .ALU_LAT(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst1_n),
        .bus        (bus1),
        .alu_a      (alu_a1),
        .alu_b      (alu_b1),
        .alu_ctrl   (alu_ctrl1),
        .alu_result (alu_res1)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops   (perf_ops1),
        .perf_err   (perf_err1)
`endif
    );

    alu_issue_ctrl #(.DATA_W(16), .TAG_W(4), .ALU_LAT(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst4_n),
        .bus        (bus4),
        .alu_a      (alu_a4),
        .alu_b      (alu_b4),
        .alu_ctrl   (alu_ctrl4),
        .alu_result (alu_res4)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_ops   (perf_ops4),
        .perf_err   (perf_err4)
`endif
    );

    // Shared drive, gated by sel so only the selected instance sees a request.
    logic        sel = 1'b0;
    logic        drv_valid = 1'b0;
    logic [2:0]  drv_op = 3'b0;
    logic [15:0] drv_a = 16'h0;
    logic [15:0] drv_b = 16'h0;
    logic [3:0]  drv_tag = 4'h0;
    logic        drv_rsp_ready = 1'b0;

    assign bus1.req_valid = drv_valid && !sel;
    assign bus4.req_valid = drv_valid && sel;
    assign bus1.rsp_ready = drv_rsp_ready && !sel;
    assign bus4.rsp_ready = drv_rsp_ready && sel;
    assign bus1.req_op = drv_op;
    assign bus4.req_op = drv_op;
    assign bus1.req_a = drv_a;
    assign bus4.req_a = drv_a;
    assign bus1.req_b = drv_b;
    assign bus4.req_b = drv_b;
    assign bus1.req_tag = drv_tag;
    assign bus4.req_tag = drv_tag;

    logic        mon_req_ready, mon_rsp_valid, mon_zero, mon_neg, mon_err;
    logic [15:0] mon_result, mon_alu_a, mon_alu_b;
    logic [3:0]  mon_tag;
    logic [2:0]  mon_alu_ctrl;

    always_comb begin
        mon_req_ready = sel ? bus4.req_ready  : bus1.req_ready;
        mon_rsp_valid = sel ? bus4.rsp_valid  : bus1.rsp_valid;
        mon_result    = sel ? bus4.rsp_result : bus1.rsp_result;
        mon_tag       = sel ? bus4.rsp_tag    : bus1.rsp_tag;
        mon_zero      = sel ? bus4.rsp_zero   : bus1.rsp_zero;
        mon_neg       = sel ? bus4.rsp_neg    : bus1.rsp_neg;
        mon_err       = sel ? bus4.rsp_err    : bus1.rsp_err;
        mon_alu_a     = sel ? alu_a4          : alu_a1;
        mon_alu_b     = sel ? alu_b4          : alu_b1;
        mon_alu_ctrl  = sel ? alu_ctrl4       : alu_ctrl1;
    end

    typedef struct {
        logic        sel;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic [15:0] res;
        logic        zero;
        logic        neg;
        logic        err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  tag;
        logic        zero;
        logic        neg;
        logic        err;
    } exp_t;

    vec_t        vecs[9];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt[2] = '{0, 0};
    int          err_cnt[2] = '{0, 0};
    logic [15:0] last_a[2] = '{16'h0, 16'h0};
    logic [15:0] last_b[2] = '{16'h0, 16'h0};
    logic [2:0]  last_ctrl[2] = '{3'h0, 3'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        check({name, "_req_ready"}, 32'(mon_req_ready), 32'd1);
        check({name, "_rsp_valid"}, 32'(mon_rsp_valid), 32'd0);
        check({name, "_rsp_result"}, 32'(mon_result), 32'd0);
        check({name, "_rsp_tag"}, 32'(mon_tag), 32'd0);
        check({name, "_rsp_flags"}, 32'({mon_zero, mon_neg, mon_err}), 32'd0);
        check({name, "_alu_a"}, 32'(mon_alu_a), 32'd0);
        check({name, "_alu_b"}, 32'(mon_alu_b), 32'd0);
        check({name, "_alu_ctrl"}, 32'(mon_alu_ctrl), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int   w;
        int   lat;
        int   s;
        exp_t e;
        s   = v.sel ? 1 : 0;
        sel = v.sel;
        w   = 0;
        while (!mon_req_ready && w < 20) begin
            @(posedge clk);
            @(negedge clk);
            w++;
        end
        check("req_ready_before_issue", 32'(mon_req_ready), 32'd1);
        drv_valid = 1'b1;
        drv_op = v.op;
        drv_a = v.a;
        drv_b = v.b;
        drv_tag = v.tag;
        // Without backpressure, rsp_ready is already high while IDLE/EXEC.
        drv_rsp_ready = (v.hold == 0);
        @(posedge clk);
        exp_q.push_back('{res: v.res, tag: v.tag, zero: v.zero, neg: v.neg, err: v.err});
        @(negedge clk);
        // Keep a different request on the bus; it must be ignored while busy.
        drv_op = ~v.op;
        drv_a = ~v.a;
        drv_b = v.a ^ 16'h5a5a;
        drv_tag = ~v.tag;
        // Edges after the accepting edge until rsp_valid is seen.
        lat = 0;
        while (!mon_rsp_valid && lat < 20) begin
            check("req_ready_low_in_exec", 32'(mon_req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), v.err ? 32'd0 : (v.sel ? 32'd4 : 32'd1));
        for (int h = 0; h < v.hold; h++) begin
            check("bp_rsp_valid", 32'(mon_rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(mon_result), 32'(v.res));
            check("bp_rsp_tag", 32'(mon_tag), 32'(v.tag));
            check("bp_req_ready", 32'(mon_req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        drv_valid = 1'b0;
        drv_rsp_ready = 1'b1;
        check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_valid", 32'(mon_rsp_valid), 32'd1);
            check("rsp_result", 32'(mon_result), 32'(e.res));
            check("rsp_tag", 32'(mon_tag), 32'(e.tag));
            check("rsp_zero", 32'(mon_zero), 32'(e.zero));
            check("rsp_neg", 32'(mon_neg), 32'(e.neg));
            check("rsp_err", 32'(mon_err), 32'(e.err));
        end
        @(posedge clk);
        @(negedge clk);
        drv_rsp_ready = 1'b0;
        done_cnt[s]++;
        if (v.err) err_cnt[s]++;
        check("rsp_valid_cleared", 32'(mon_rsp_valid), 32'd0);
        check("req_ready_after_rsp", 32'(mon_req_ready), 32'd1);
        if (!v.err) begin
            last_a[s]    = v.a;
            last_b[s]    = v.b;
            last_ctrl[s] = v.op;
        end
        check("alu_a", 32'(mon_alu_a), 32'(last_a[s]));
        check("alu_b", 32'(mon_alu_b), 32'(last_b[s]));
        check("alu_ctrl", 32'(mon_alu_ctrl), 32'(last_ctrl[s]));
    endtask

    task automatic reset_mid_exec();
        int seen;
        sel = 1'b1;
        drv_valid = 1'b1;
        drv_op = 3'b001;
        drv_a = 16'h0001;
        drv_b = 16'h0002;
        drv_tag = 4'hA;
        drv_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        check("rst_seq_in_exec", 32'(mon_req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst4_n = 1'b0;
        #1;
        check_idle_zero("mid_exec_reset");
        @(negedge clk);
        rst4_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (mon_rsp_valid) seen++;
        end
        check("no_rsp_after_reset", 32'(seen), 32'd0);
        drv_rsp_ready = 1'b0;
        last_a[1] = 16'h0;
        last_b[1] = 16'h0;
        last_ctrl[1] = 3'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sel   op      a         b         tag   res       z     n     e     hold
        vecs[0] = '{1'b0, 3'b001, 16'h0003, 16'h0004, 4'h5, 16'h0007, 1'b0, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b0, 3'b000, 16'h1234, 16'h1234, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b0, 3'b000, 16'h0001, 16'h0002, 4'h2, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 3'b111, 16'h0055, 16'h0066, 4'h9, 16'h0000, 1'b1, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 3'b010, 16'h0100, 16'h0100, 4'h3, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
        vecs[5] = '{1'b0, 3'b100, 16'hF0F0, 16'h3C3C, 4'h4, 16'h3030, 1'b0, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b0, 3'b110, 16'h8000, 16'h0000, 4'h6, 16'h4000, 1'b0, 1'b0, 1'b0, 2};
        vecs[7] = '{1'b1, 3'b011, 16'h000A, 16'hFFFF, 4'h7, 16'h0003, 1'b0, 1'b0, 1'b0, 0};
        vecs[8] = '{1'b1, 3'b101, 16'h8001, 16'h0000, 4'hC, 16'h0002, 1'b0, 1'b0, 1'b0, 0};

        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        check_idle_zero("reset_lat1");
        sel = 1'b1;
        #1;
        check_idle_zero("reset_lat4");
        @(negedge clk);
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (i == 8) reset_mid_exec();
            run_vec(vecs[i]);
        end

`ifdef ALU_ISSUE_PERF_EN
        check("perf_ops_lat1", perf_ops1, 32'(done_cnt[0]));
        check("perf_err_lat1", 32'(perf_err1), 32'(err_cnt[0]));
        check("perf_ops_lat4", perf_ops4, 32'(done_cnt[1]));
        check("perf_err_lat4", 32'(perf_err4), 32'(err_cnt[1]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
